// File: rtl/clk_ratio_meter_if.sv
// clk_ratio_meter_if: measured clock input and measurement results of clk_ratio_meter
interface clk_ratio_meter_if;
  logic       clkin;
  logic [7:0] ratio;
  logic [7:0] hi_cnt;
  logic       upd;
  logic       locked;
  logic       stall;
  modport master (input clkin, output ratio, hi_cnt, upd, locked, stall);
  modport slave (output clkin, input ratio, hi_cnt, upd, locked, stall);
endinterface

// File: rtl/clk_ratio_meter.sv
// clk_ratio_meter: measures clkin period and high time in clk cycles, with lock and stall detection
// Define CLK_RATIO_METER_DUTY_EN to build the high-time accumulator; otherwise hi_cnt is tied to 0.
module clk_ratio_meter #(
  parameter int LOCK_CNT = 4
) (
  input logic clk,
  input logic rst_n,
  clk_ratio_meter_if.master m
);
  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;
  localparam logic [3:0] MMAX = 4'(LOCK_CNT - 1);
  state_t state, state_nx;
  logic s1, s2, s3, rise, tmo, load, cmp_eq;
  logic [7:0] cnt;
  logic [3:0] mcnt;
  assign rise = s2 & ~s3;
  assign tmo = ~rise & (cnt == 8'd255);
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = rise ? (state == IDLE ? ARM : MEAS) : (tmo ? IDLE : state);
  always_comb begin
    load = rise & (state != IDLE);
    cmp_eq = rise & (state == MEAS) & (cnt == m.ratio);
  end
  always_ff @(posedge clk)
    if (!rst_n) {s1, s2, s3} <= '0;
    else {s1, s2, s3} <= {m.clkin, s1, s2};
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else cnt <= rise ? 8'd1 : cnt + {7'd0, cnt != 8'd255};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m.ratio <= '0;
      m.upd <= 1'b0;
      m.locked <= 1'b0;
      m.stall <= 1'b0;
      mcnt <= '0;
    end else begin
      m.upd <= load;
      if (load) begin
        m.ratio <= cnt;
        mcnt <= cmp_eq ? (mcnt == MMAX ? MMAX : mcnt + 4'd1) : 4'd0;
        m.locked <= cmp_eq & (m.locked | ((mcnt + 4'd1) >= MMAX));
      end else if (tmo) begin
        m.ratio <= '0;
        m.locked <= 1'b0;
        mcnt <= '0;
      end
      if (rise) m.stall <= 1'b0;
      else if (tmo) m.stall <= 1'b1;
    end
  end
`ifdef CLK_RATIO_METER_DUTY_EN
  logic [7:0] hacc;
  always_ff @(posedge clk)
    if (!rst_n) hacc <= '0;
    else hacc <= rise ? 8'd1 : hacc + {7'd0, s2 && hacc != 8'd255};
  always_ff @(posedge clk)
    if (!rst_n) m.hi_cnt <= '0;
    else if (load) m.hi_cnt <= hacc;
    else if (tmo) m.hi_cnt <= '0;
`else
  assign m.hi_cnt = '0;
`endif
endmodule

// File: tb/tb_clk_ratio_meter.sv
// tb_clk_ratio_meter: randomized scoreboard bench for clk_ratio_meter against an event-level period model
module tb_clk_ratio_meter;
  localparam int LOCK_CNT = 4;
  typedef struct {
    int e;
    int ratio;
    int hi;
    bit locked;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  clk_ratio_meter_if bus ();
  clk_ratio_meter #(.LOCK_CNT(LOCK_CNT)) dut (.clk(clk), .rst_n(rst_n), .m(bus.master));
  always #5 clk = ~clk;
  exp_t sbq[$];
  int smp[$];
  int hist[$];
  int checks = 0, errors = 0;
  int edge_n = -1, origin = 0, last_rise = 0, cb, hc;
  bit armed = 0, exp_stall = 0, was_rst = 0, rz, lk;
  // Reference: periods are differences between synchronized rise edges; the
  // synchronized view of clkin lags the posedge sample by two clk edges.
  always @(posedge clk) begin
    edge_n++;
    smp.push_back(rst_n ? int'(bus.clkin) : 0);
    was_rst = !rst_n;
    if (!rst_n) begin
      origin = edge_n;
      armed = 0;
      hist.delete();
      exp_stall = 0;
    end else begin
      rz = edge_n >= 3 && smp[edge_n-2] == 1 && smp[edge_n-3] == 0;
      cb = edge_n - 1 - origin;
      if (cb > 255) cb = 255;
      if (rz) begin
        if (armed) begin
          hc = 0;
          for (int y = last_rise; y < edge_n; y++) hc += smp[y-2];
          if (hc > 255) hc = 255;
`ifndef CLK_RATIO_METER_DUTY_EN
          hc = 0;
`endif
          hist.push_back(cb);
          if (hist.size() > LOCK_CNT) void'(hist.pop_front());
          lk = hist.size() == LOCK_CNT;
          foreach (hist[i]) if (hist[i] != cb) lk = 0;
          sbq.push_back('{edge_n, cb, hc, lk});
        end
        armed = 1;
        exp_stall = 0;
        origin = edge_n - 1;
        last_rise = edge_n;
      end else if (cb == 255) begin
        armed = 0;
        hist.delete();
        exp_stall = 1;
      end
    end
  end
  always @(negedge clk) begin
    exp_t x;
    if (edge_n >= 0) begin
      checks++;
      if (bus.stall !== exp_stall) begin
        errors++;
        $display("FAIL stall edge %0d: got %0b, expected %0b", edge_n, bus.stall, exp_stall);
      end
      if (was_rst) begin
        checks++;
        if ({bus.ratio, bus.hi_cnt, bus.upd, bus.locked, bus.stall} !== 19'd0) begin
          errors++;
          $display("FAIL reset_outputs edge %0d: ratio=%0d hi=%0d upd=%0b locked=%0b stall=%0b, expected all 0",
                   edge_n, bus.ratio, bus.hi_cnt, bus.upd, bus.locked, bus.stall);
        end
      end
      if (bus.stall === 1'b1) begin
        checks++;
        if ({bus.ratio, bus.hi_cnt, bus.locked} !== 17'd0) begin
          errors++;
          $display("FAIL stall_outputs edge %0d: ratio=%0d hi=%0d locked=%0b, expected 0/0/0",
                   edge_n, bus.ratio, bus.hi_cnt, bus.locked);
        end
      end
      if (bus.upd === 1'b1) begin
        checks++;
        if (sbq.size() == 0 || sbq[0].e != edge_n) begin
          errors++;
          $display("FAIL upd_unexpected edge %0d: got upd=1 ratio=%0d, expected no update", edge_n, bus.ratio);
        end else begin
          x = sbq.pop_front();
          if (bus.ratio !== 8'(x.ratio) || bus.hi_cnt !== 8'(x.hi) || bus.locked !== x.locked) begin
            errors++;
            $display("FAIL measurement edge %0d: got ratio=%0d hi=%0d locked=%0b, expected ratio=%0d hi=%0d locked=%0b",
                     edge_n, bus.ratio, bus.hi_cnt, bus.locked, x.ratio, x.hi, x.locked);
          end
        end
      end else if (sbq.size() != 0 && sbq[0].e <= edge_n) begin
        checks++;
        errors++;
        $display("FAIL upd_missing edge %0d: got upd=%0b, expected upd=1 ratio=%0d", edge_n, bus.upd, sbq[0].ratio);
        void'(sbq.pop_front());
      end
    end
  end
  task automatic run_div(input int hi_h, input int lo_h, input int n);
    repeat (n) begin
      bus.clkin = 1'b1;
      #(hi_h * 5);
      bus.clkin = 1'b0;
      #(lo_h * 5);
    end
  endtask
  task automatic hold(input logic v, input int ncyc);
    bus.clkin = v;
    #(ncyc * 10);
  endtask
  task automatic run_fast(input int ncyc);
    repeat (ncyc) begin
      @(negedge clk);
      #1 bus.clkin = 1'b1;
      @(posedge clk);
      #1 bus.clkin = 1'b0;
    end
  endtask
  initial begin
    int hi, lo;
    bus.clkin = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    hold(1'b0, 4);
    run_div(6, 6, 8);
    run_div(4, 6, 8);
    hold(1'b0, 300);
    run_div(6, 6, 4);
    run_div(5, 5, 10);
    run_div(8, 8, 6);
    bus.clkin = 1'b1;
    #40;
    bus.clkin = 1'b0;
    #20;
    rst_n = 1'b0;
    #10;
    rst_n = 1'b1;
    #10;
    run_div(8, 8, 5);
    hold(1'b1, 300);
    bus.clkin = 1'b0;
    #30;
    run_fast(300);
    hold(1'b0, 4);
    run_div(2, 506, 2);
    run_div(2, 508, 5);
    run_div(2, 510, 3);
    run_div(6, 6, 3);
    repeat (40) begin
      hi = $urandom_range(2, 24);
      lo = $urandom_range(2, 24);
      run_div(hi, lo, $urandom_range(1, 7));
      if ($urandom_range(0, 9) == 0) hold(1'b0, $urandom_range(200, 300));
    end
    hold(1'b0, 20);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL pending_updates: got %0d unconsumed, expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
